writeback_merge: RTL
====================

Name: writeback_merge

Overview:
- Writeback-side producer for the dual-write-port register file.
- Each cycle it merges three result sources into the file's two write ports (write_enable[1:0], waddrA/wdataA, waddrB/wdataB): ALU lane A, ALU lane B, and variable-latency load returns from data memory.
- Load results that cannot get a port wait in a small in-order queue. The block squashes stale loads to preserve write-after-write order and exports a pending-destination mask that decode uses for load-use stalls.

Parameters:
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register index width (2**ADDR_WIDTH registers)
- LQ_DEPTH, 4, load-queue entries; power of two, at least 2

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- a_valid  in  1  lane A result valid
- a_rd  in  ADDR_WIDTH  lane A destination
- a_data  in  DATA_WIDTH  lane A result
- b_valid  in  1  lane B result valid (lane B is younger than lane A)
- b_rd  in  ADDR_WIDTH  lane B destination
- b_data  in  DATA_WIDTH  lane B result
- ld_valid  in  1  load return valid
- ld_rd  in  ADDR_WIDTH  load destination
- ld_data  in  DATA_WIDTH  load data
- ld_ready  out  1  load accepted this cycle when ld_valid=1; equals !full
- write_enable  out  2  bit1 = port A, bit0 = port B
- waddrA  out  ADDR_WIDTH  port A address
- wdataA  out  DATA_WIDTH  port A data
- waddrB  out  ADDR_WIDTH  port B address
- wdataB  out  DATA_WIDTH  port B data
- pending_mask  out  2**ADDR_WIDTH  bit r set while a live queued load targets register r
- lq_count  out  $clog2(LQ_DEPTH)+1  occupied queue entries, live and squashed

Behaviour:
- Reset (async assert, sync deassert by clk):
  - write_enable=0; waddrA/B=0; wdataA/B=0.
  - Queue empty, pending_mask=0, lq_count=0, ld_ready=1.
- All port outputs are registered. A lane result presented in cycle N drives the port in cycle N+1, and the register file commits it at the following edge.
- Lane filtering:
  - rd=0 results are discarded and never use a port.
  - If a_valid and b_valid both target the same nonzero rd, lane A is dropped (B is younger).
- Port assignment, evaluated each cycle:
  - Live lane A goes to port A; live lane B goes to port B.
  - The queue head is live only if its entry is valid. It takes port A if lane A is not live, otherwise port B if lane B is not live, otherwise it waits.
  - At most one queue pop per cycle.
- Load enqueue:
  - A load is accepted when ld_valid && ld_ready and lands at the tail at the edge.
  - Accepted loads are never popped in their arrival cycle, so minimum load latency is cycle N to port in N+2.
  - ld_rd=0 is accepted but stored squashed.
- Squash (WAW rule):
  - Load returns are older than any same-cycle or later lane result.
  - Any live lane write to rd clears the valid bit of every queued entry with that rd, including the head and any entry being enqueued that cycle.
  - A squashed head is popped without using a port and still counts as the one pop for that cycle.
- Full/empty:
  - ld_ready=0 when lq_count==LQ_DEPTH; full is evaluated on registered state and does not depend on a same-cycle pop.
  - On an empty queue, no head is considered.
- Pointers: read and write pointers are $clog2(LQ_DEPTH) bits wide and wrap naturally; a separate count distinguishes full from empty.
- pending_mask:
  - Registered OR of one-hot(rd) over valid entries, reflecting post-edge state.
  - Bit 0 is always 0.
- Simultaneous events:
  - Enqueue and pop in the same cycle leave lq_count unchanged.
  - Squash and enqueue of the same rd in the same cycle stores the entry invalid.
- Reset mid-operation: all queued loads are discarded and outputs return to reset values immediately, without waiting for clk.

Decomposition:
- Shared package wb_pkg:
  - WB_DATA_WIDTH and WB_ADDR_WIDTH constants.
  - typedef wb_req_t {valid, rd, data}, used for lane and load inputs.
  - typedef lq_entry_t {valid, rd, data}.
- One natural sub-module, wb_load_queue:
  - Holds the circular buffer, pointers, count, the per-entry squash compare against two rd values, and pending_mask generation.
  - The top level keeps lane filtering, port assignment and the output registers.

Test Plan:
- Lane-only writes: a=(x5,0x11), b=(x6,0x22) in cycle 0 -> cycle 1 write_enable=2'b11, waddrA=5, wdataA=0x11, waddrB=6, wdataB=0x22. In cycle 2 write_enable=0.
- Same-rd conflict: a=(x7,0xAA), b=(x7,0xBB) -> write_enable=2'b01, waddrB=7, wdataB=0xBB; port A idle.
- Load port steal: load (x9,0xDEAD) at cycle 0, then only lane A live (x3) in cycle 1 -> cycle 2 port A=x3 and port B=(x9,0xDEAD). pending_mask[9] is 1 during cycle 1 and 0 in cycle 2.
- Backpressure and full:
  - Hold both lanes busy with nonzero distinct rds.
  - Send 5 loads (x10..x14) -> ld_ready=0 on the 5th request once lq_count=4.
  - Release the lanes -> loads drain in order x10..x13 at one per cycle, then x14 is accepted and drains.
- WAW squash: queue load x12 while lanes are busy, then lane B writes x12=0x55 -> the load is never written, pending_mask[12] clears, and the entry is popped with no port use.
- Async reset: assert reset low mid-drain with 3 queued entries -> outputs are zero before the next clk edge. After release, lq_count=0 and ld_ready=1, and a new load to x1 is written at N+2.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback merge block and its load queue.
package wb_pkg;

    localparam int unsigned WB_DATA_WIDTH = 32;
    localparam int unsigned WB_ADDR_WIDTH = 5;
    localparam int unsigned WB_NUM_REGS   = 1 << WB_ADDR_WIDTH;

    // One result presented to the writeback stage (ALU lane or load return)
    typedef struct packed {
        logic                     valid;
        logic [WB_ADDR_WIDTH-1:0] rd;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_req_t;

    // One load-queue slot; valid=0 marks a squashed or empty entry
    typedef struct packed {
        logic                     valid;
        logic [WB_ADDR_WIDTH-1:0] rd;
        logic [WB_DATA_WIDTH-1:0] data;
    } lq_entry_t;

    // True when a live writer targets the given register
    function automatic logic rd_hit(input logic                     wr_valid,
                                    input logic [WB_ADDR_WIDTH-1:0] wr_rd,
                                    input logic [WB_ADDR_WIDTH-1:0] rd);
        return wr_valid && (wr_rd == rd);
    endfunction

endpackage

// File: rtl/wb_load_queue.sv
// In-order load-return queue with WAW squash and pending-destination tracking.
module wb_load_queue
    import wb_pkg::*;
#(
    parameter int unsigned LQ_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enq,
    input  logic [WB_ADDR_WIDTH-1:0]   enq_rd,
    input  logic [WB_DATA_WIDTH-1:0]   enq_data,
    input  logic                       sq_a_valid,
    input  logic [WB_ADDR_WIDTH-1:0]   sq_a_rd,
    input  logic                       sq_b_valid,
    input  logic [WB_ADDR_WIDTH-1:0]   sq_b_rd,
    input  logic                       pop,
    output logic                       head_live_c,
    output logic [WB_ADDR_WIDTH-1:0]   head_rd_c,
    output logic [WB_DATA_WIDTH-1:0]   head_data_c,
    output logic                       empty_c,
    output logic                       ready,
    output logic [$clog2(LQ_DEPTH):0]  count,
    output logic [WB_NUM_REGS-1:0]     pending_mask
);

    localparam int unsigned PTR_W = $clog2(LQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    lq_entry_t                ent_q [LQ_DEPTH];
    lq_entry_t                ent_n [LQ_DEPTH];
    logic [PTR_W-1:0]         rptr_q;
    logic [PTR_W-1:0]         wptr_q;
    logic [CNT_W-1:0]         count_n;
    logic [WB_NUM_REGS-1:0]   mask_n;
    lq_entry_t                head;

    // Head view; a same-cycle lane write to the head's rd kills it before it can claim a port
    always_comb begin
        head        = ent_q[rptr_q];
        empty_c     = (count == '0);
        head_rd_c   = head.rd;
        head_data_c = head.data;
        head_live_c = !empty_c && head.valid
                      && !rd_hit(sq_a_valid, sq_a_rd, head.rd)
                      && !rd_hit(sq_b_valid, sq_b_rd, head.rd);
    end

    // Next queue contents: squash, pop, enqueue, then rebuild the pending mask
    always_comb begin
        for (int i = 0; i < int'(LQ_DEPTH); i++) begin
            ent_n[i] = ent_q[i];
            if (rd_hit(sq_a_valid, sq_a_rd, ent_q[i].rd) || rd_hit(sq_b_valid, sq_b_rd, ent_q[i].rd)) begin
                ent_n[i].valid = 1'b0;
            end
        end
        if (pop) begin
            ent_n[rptr_q].valid = 1'b0;
        end
        if (enq) begin
            ent_n[wptr_q].valid = (enq_rd != '0)
                                  && !rd_hit(sq_a_valid, sq_a_rd, enq_rd)
                                  && !rd_hit(sq_b_valid, sq_b_rd, enq_rd);
            ent_n[wptr_q].rd    = enq_rd;
            ent_n[wptr_q].data  = enq_data;
        end

        count_n = count;
        if (enq && !pop) begin
            count_n = count + CNT_W'(1);
        end else if (!enq && pop) begin
            count_n = count - CNT_W'(1);
        end

        mask_n = '0;
        for (int i = 0; i < int'(LQ_DEPTH); i++) begin
            if (ent_n[i].valid) begin
                mask_n[ent_n[i].rd] = 1'b1;
            end
        end
        mask_n[0] = 1'b0;
    end

    // Queue state and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(LQ_DEPTH); i++) begin
                ent_q[i] <= '0;
            end
            rptr_q       <= '0;
            wptr_q       <= '0;
            count        <= '0;
            ready        <= 1'b1;
            pending_mask <= '0;
        end else begin
            for (int i = 0; i < int'(LQ_DEPTH); i++) begin
                ent_q[i] <= ent_n[i];
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            if (enq) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            count        <= count_n;
            ready        <= (count_n != CNT_W'(LQ_DEPTH));
            pending_mask <= mask_n;
        end
    end

endmodule

// File: rtl/writeback_merge.sv
// Merges two ALU lanes and queued load returns onto the register file's two write ports.
module writeback_merge
    import wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int unsigned LQ_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        a_valid,
    input  logic [ADDR_WIDTH-1:0]       a_rd,
    input  logic [DATA_WIDTH-1:0]       a_data,
    input  logic                        b_valid,
    input  logic [ADDR_WIDTH-1:0]       b_rd,
    input  logic [DATA_WIDTH-1:0]       b_data,
    input  logic                        ld_valid,
    input  logic [ADDR_WIDTH-1:0]       ld_rd,
    input  logic [DATA_WIDTH-1:0]       ld_data,
    output logic                        ld_ready,
    output logic [1:0]                  write_enable,
    output logic [ADDR_WIDTH-1:0]       waddrA,
    output logic [DATA_WIDTH-1:0]       wdataA,
    output logic [ADDR_WIDTH-1:0]       waddrB,
    output logic [DATA_WIDTH-1:0]       wdataB,
    output logic [2**ADDR_WIDTH-1:0]    pending_mask,
    output logic [$clog2(LQ_DEPTH):0]   lq_count
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

    wb_req_t                  lane_a;
    wb_req_t                  lane_b;
    wb_req_t                  ld_req;
    logic                     a_live;
    logic                     b_live;
    logic                     enq;
    logic                     pop;
    logic                     head_live_c;
    logic [WB_ADDR_WIDTH-1:0] head_rd_c;
    logic [WB_DATA_WIDTH-1:0] head_data_c;
    logic                     empty_c;
    logic                     lq_ready;
    logic [WB_NUM_REGS-1:0]   lq_mask;
    logic [1:0]               we_n;
    logic [WB_ADDR_WIDTH-1:0] addr_a_n;
    logic [WB_DATA_WIDTH-1:0] data_a_n;
    logic [WB_ADDR_WIDTH-1:0] addr_b_n;
    logic [WB_DATA_WIDTH-1:0] data_b_n;

    // Bundle inputs and filter lanes: x0 never writes, and B (younger) wins a same-rd clash
    always_comb begin
        lane_a = '{valid: a_valid,  rd: WB_ADDR_WIDTH'(a_rd),  data: WB_DATA_WIDTH'(a_data)};
        lane_b = '{valid: b_valid,  rd: WB_ADDR_WIDTH'(b_rd),  data: WB_DATA_WIDTH'(b_data)};
        ld_req = '{valid: ld_valid, rd: WB_ADDR_WIDTH'(ld_rd), data: WB_DATA_WIDTH'(ld_data)};
        b_live = lane_b.valid && (lane_b.rd != '0);
        a_live = lane_a.valid && (lane_a.rd != '0) && !(b_live && (lane_b.rd == lane_a.rd));
        enq    = ld_req.valid && lq_ready;
        // A dead head always leaves; a live head leaves only if some port is free
        pop    = !empty_c && !(head_live_c && a_live && b_live);
    end

    wb_load_queue #(
        .LQ_DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk          (clk),
        .reset        (reset),
        .enq          (enq),
        .enq_rd       (ld_req.rd),
        .enq_data     (ld_req.data),
        .sq_a_valid   (a_live),
        .sq_a_rd      (lane_a.rd),
        .sq_b_valid   (b_live),
        .sq_b_rd      (lane_b.rd),
        .pop          (pop),
        .head_live_c  (head_live_c),
        .head_rd_c    (head_rd_c),
        .head_data_c  (head_data_c),
        .empty_c      (empty_c),
        .ready        (lq_ready),
        .count        (lq_count),
        .pending_mask (lq_mask)
    );

    assign ld_ready     = lq_ready;
    assign pending_mask = NUM_REGS'(lq_mask);

    // Port assignment: lanes own their ports, the queue head fills port A first, then port B
    always_comb begin
        we_n     = '0;
        addr_a_n = '0;
        data_a_n = '0;
        addr_b_n = '0;
        data_b_n = '0;
        if (a_live) begin
            we_n[1]  = 1'b1;
            addr_a_n = lane_a.rd;
            data_a_n = lane_a.data;
        end else if (head_live_c) begin
            we_n[1]  = 1'b1;
            addr_a_n = head_rd_c;
            data_a_n = head_data_c;
        end
        if (b_live) begin
            we_n[0]  = 1'b1;
            addr_b_n = lane_b.rd;
            data_b_n = lane_b.data;
        end else if (head_live_c && a_live) begin
            we_n[0]  = 1'b1;
            addr_b_n = head_rd_c;
            data_b_n = head_data_c;
        end
    end

    // Registered write ports
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_enable <= '0;
            waddrA       <= '0;
            wdataA       <= '0;
            waddrB       <= '0;
            wdataB       <= '0;
        end else begin
            write_enable <= we_n;
            waddrA       <= ADDR_WIDTH'(addr_a_n);
            wdataA       <= DATA_WIDTH'(data_a_n);
            waddrB       <= ADDR_WIDTH'(addr_b_n);
            wdataB       <= DATA_WIDTH'(data_b_n);
        end
    end

endmodule
